spc7110_direct_fetch: RTL
=========================

SPC7110_DIRECT_FETCH -- requirements
Module: spc7110_direct_fetch

Interface
REQ-001 Parameter PROGROM_SIZE, default 24'h100000, base of the data ROM region in PSRAM.
REQ-002 Parameter DATAROM_MASK, default 24'h0FFFFF, mask applied to the data-ROM-relative address.
REQ-003 Parameter TIMEOUT, default 8'd32, maximum cycles to wait for psram_ack.
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 direct_rom_rd  input  1  level; the direct-access port is requesting a data ROM byte.
REQ-007 direct_mapped_addr  input  24  PSRAM byte address requested, program ROM base already added.
REQ-008 sfc_rd_end  input  1  one-cycle pulse; the SNES read cycle ended and the requester will advance its address.
REQ-009 cache_flush  input  1  one-cycle pulse; any MMIO write altered base, offset or mode.
REQ-010 psram_req  output  1  level; read request to the PSRAM arbiter.
REQ-011 psram_addr  output  24  PSRAM read address, stable while psram_req is high.
REQ-012 psram_ack  input  1  one-cycle pulse; psram_data is valid this cycle.
REQ-013 psram_data  input  8  PSRAM read data.
REQ-014 fetch_data  output  8  byte presented to the SNES data bus.
REQ-015 fetch_valid  output  1  fetch_data corresponds to cached_addr and is usable.
REQ-016 fetch_busy  output  1  a PSRAM transaction is outstanding.

Function
REQ-017 The FSM shall have exactly four states: IDLE, REQ, VALID, and an internal HOLD state used for post-timeout recovery.
REQ-018 IDLE: when direct_rom_rd=1 and cache_flush=0, the FSM shall latch psram_addr, clear the timeout counter, and enter REQ on the next edge.
REQ-019 psram_addr shall be PROGROM_SIZE + ((direct_mapped_addr - PROGROM_SIZE) & DATAROM_MASK), computed modulo 2^24 and registered on entry to REQ.
REQ-020 REQ: psram_req and fetch_busy shall be 1; psram_addr shall not change until the transaction ends.
REQ-021 REQ with psram_ack=1: the FSM shall latch psram_data into fetch_data and direct_mapped_addr into cached_addr, set fetch_valid, deassert psram_req on the next edge, and enter VALID.
REQ-022 REQ without ack: the timeout counter shall increment by 1 each cycle.
REQ-023 Timeout: when the counter reaches TIMEOUT-1 with no ack, the FSM shall deassert psram_req, set fetch_data=8'hFF and fetch_valid=1, and enter HOLD.
REQ-024 HOLD shall behave as VALID, except that a psram_ack arriving in HOLD shall be ignored.
REQ-025 VALID/HOLD, sfc_rd_end=1: fetch_valid shall clear and the FSM shall enter IDLE.
REQ-026 VALID/HOLD, direct_rom_rd=1 with direct_mapped_addr != cached_addr: fetch_valid shall clear and the FSM shall enter REQ, with psram_addr recomputed per REQ-019.
REQ-027 cache_flush=1 in any state shall clear fetch_valid, deassert psram_req on the next edge, and enter IDLE.
REQ-028 cache_flush has priority over psram_ack in the same cycle: the ack data shall be discarded and fetch_data left unchanged.
REQ-029 sfc_rd_end has priority over an address mismatch in the same cycle.
REQ-030 Latency: with ack on the first REQ cycle, fetch_valid shall rise 2 cycles after direct_rom_rd rises.
REQ-031 fetch_data shall change only on an accepted ack (REQ-021), on a timeout (REQ-023), or on reset.
REQ-032 If direct_rom_rd deasserts while in REQ, the transaction shall still complete, because PSRAM requests are never abandoned except by flush or timeout.

Reset
REQ-033 Asserting RESET shall immediately force: FSM=IDLE, psram_req=0, psram_addr=24'h000000, fetch_data=8'h00, fetch_valid=0, fetch_busy=0, cached_addr=24'h000000, timeout counter=0.
REQ-034 Asserting RESET mid-transaction shall drop psram_req without waiting for ack; a subsequent ack shall be ignored while in IDLE.

Verification
REQ-035 direct_rom_rd=1, addr=24'h123456, ack 3 cycles later with data 8'hA5 -> psram_addr=24'h123456, fetch_data=8'hA5, fetch_valid=1.
REQ-036 addr=24'h2FFFFF (relative offset 24'h1FFFFF) -> psram_addr=24'h1FFFFF after masking.
REQ-037 No ack for TIMEOUT cycles -> psram_req=0, fetch_data=8'hFF, fetch_valid=1; a late ack leaves fetch_data=8'hFF.
REQ-038 cache_flush and psram_ack (data 8'h3C) in the same cycle -> fetch_valid=0, fetch_data unchanged, FSM=IDLE.
REQ-039 In VALID, change addr from 24'h100010 to 24'h100011 -> new psram_req issued at 24'h100011; sfc_rd_end pulse in VALID -> fetch_valid=0 next cycle.
REQ-040 RESET asserted while psram_req=1 -> psram_req=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/spc7110_direct_fetch.sv
// Direct data-ROM byte fetch for the SPC7110 port: translates the requested address into the
// data-ROM window, reads the byte from PSRAM and keeps it until the SNES read cycle ends.
module spc7110_direct_fetch #(
    parameter logic [23:0] PROGROM_SIZE = 24'h100000,
    parameter logic [23:0] DATAROM_MASK = 24'h0FFFFF,
    parameter logic [7:0]  TIMEOUT      = 8'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        direct_rom_rd,
    input  logic [23:0] direct_mapped_addr,
    input  logic        sfc_rd_end,
    input  logic        cache_flush,
    output logic        psram_req,
    output logic [23:0] psram_addr,
    input  logic        psram_ack,
    input  logic [7:0]  psram_data,
    output logic [7:0]  fetch_data,
    output logic        fetch_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_VALID,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] psram_addr_q, psram_addr_d;
    logic [7:0]  fetch_data_q, fetch_data_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [23:0] cached_addr_q, cached_addr_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;
    logic [23:0] mapped_addr;

    // Wraps the request back into the data-ROM window; all arithmetic is modulo 2^24.
    assign mapped_addr = PROGROM_SIZE + ((direct_mapped_addr - PROGROM_SIZE) & DATAROM_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            psram_addr_q  <= 24'h000000;
            fetch_data_q  <= 8'h00;
            fetch_valid_q <= 1'b0;
            cached_addr_q <= 24'h000000;
            timeout_cnt_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            psram_addr_q  <= psram_addr_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            cached_addr_q <= cached_addr_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        psram_addr_d  = psram_addr_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = fetch_valid_q;
        cached_addr_d = cached_addr_q;
        timeout_cnt_d = timeout_cnt_q;

        // A flush outranks everything, including an ack landing in the same cycle.
        if (cache_flush) begin
            state_d       = ST_IDLE;
            fetch_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (direct_rom_rd) begin
                        psram_addr_d  = mapped_addr;
                        timeout_cnt_d = 8'h00;
                        state_d       = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (psram_ack) begin
                        fetch_data_d  = psram_data;
                        cached_addr_d = direct_mapped_addr;
                        fetch_valid_d = 1'b1;
                        state_d       = ST_VALID;
                    end else if (timeout_cnt_q == TIMEOUT - 8'd1) begin
                        fetch_data_d  = 8'hFF;
                        cached_addr_d = direct_mapped_addr;
                        fetch_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end
                // HOLD only differs from VALID in that a late ack never reaches this logic.
                ST_VALID, ST_HOLD: begin
                    if (sfc_rd_end) begin
                        fetch_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end else if (direct_rom_rd && (direct_mapped_addr != cached_addr_q)) begin
                        fetch_valid_d = 1'b0;
                        psram_addr_d  = mapped_addr;
                        timeout_cnt_d = 8'h00;
                        state_d       = ST_REQ;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign psram_req   = (state_q == ST_REQ);
    assign fetch_busy  = (state_q == ST_REQ);
    assign psram_addr  = psram_addr_q;
    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;

endmodule
